// File: rtl/sms_pkg.sv
// Shared types and constants for the SMS memory mapper.
package sms_pkg;

   typedef enum logic [1:0] {
      REG_ROM,
      REG_CRAM,
      REG_RAM
   } region_e;

   typedef enum logic [1:0] {
      IDLE,
      ROM_REQ,
      DONE
   } state_e;

   localparam logic [15:0] MAP_CTL = 16'hFFFC;
   localparam logic [15:0] MAP_B0  = 16'hFFFD;
   localparam logic [15:0] MAP_B1  = 16'hFFFE;
   localparam logic [15:0] MAP_B2  = 16'hFFFF;

   localparam logic [7:0] BANK0_RST = 8'h00;
   localparam logic [7:0] BANK1_RST = 8'h01;
   localparam logic [7:0] BANK2_RST = 8'h02;

   // Only the cartridge-RAM enable/bank bits of the control register affect decode.
   typedef struct packed {
      logic       cram_en;
      logic       cram_bank;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
   } map_regs_t;

endpackage

// File: rtl/sms_mapper_decode.sv
// Combinational CPU-address decode into ROM / cartridge RAM / system RAM targets.
module sms_mapper_decode
   import sms_pkg::*;
#(
   parameter int unsigned ROM_AW  = 22,
   parameter int unsigned RAM_AW  = 13,
   parameter int unsigned CRAM_AW = 15
) (
   input  logic [15:0]        addr_i,
   input  map_regs_t          regs_i,
   output region_e            region_o,
   output logic [ROM_AW-1:0]  rom_addr_o,
   output logic [RAM_AW-1:0]  ram_addr_o,
   output logic [CRAM_AW-1:0] cram_addr_o
);

   localparam int unsigned BANK_W = ROM_AW - 14;

   logic [7:0] bank;

   always_comb begin
      bank     = 8'h00;
      region_o = REG_ROM;
      unique case (addr_i[15:14])
         2'b00: bank = (addr_i[13:10] == 4'h0) ? 8'h00 : regs_i.b0;
         2'b01: bank = regs_i.b1;
         2'b10: begin
            if (regs_i.cram_en) region_o = REG_CRAM;
            else                bank     = regs_i.b2;
         end
         default: region_o = REG_RAM;
      endcase
   end

   // Bank numbers beyond the ROM size wrap through truncation to BANK_W bits.
   assign rom_addr_o  = {BANK_W'(bank), addr_i[13:0]};
   assign ram_addr_o  = addr_i[RAM_AW-1:0];
   assign cram_addr_o = CRAM_AW'({regs_i.cram_bank, addr_i[13:0]});

endmodule

// File: rtl/sms_mapper.sv
// Z80 bus to SMS memory translator: mapper registers, write strobes and ROM wait-state FSM.
module sms_mapper
   import sms_pkg::*;
#(
   parameter int unsigned ROM_AW  = 22,
   parameter int unsigned RAM_AW  = 13,
   parameter int unsigned CRAM_AW = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [15:0]        z_addr,
   input  logic [7:0]         z_dout,
   output logic [7:0]         z_din,
   input  logic               z_nmreq,
   input  logic               z_nrd,
   input  logic               z_nwr,
   input  logic               z_nrfsh,
   output logic               z_nwait,
   output logic [ROM_AW-1:0]  rom_addr,
   output logic               rom_rd,
   input  logic               rom_ready,
   input  logic [7:0]         rom_data,
   output logic [RAM_AW-1:0]  ram_addr,
   output logic               ram_we,
   input  logic [7:0]         ram_q,
   output logic [CRAM_AW-1:0] cram_addr,
   output logic               cram_we,
   input  logic [7:0]         cram_q
);

   map_regs_t          regs_q;
   state_e             state_q;
   logic               wr_prev_q;
   logic               abort_q;
   logic [7:0]         z_din_q;
   logic [ROM_AW-1:0]  rom_addr_q;

   region_e            region;
   logic [ROM_AW-1:0]  dec_rom_addr;
   logic               rd_act;
   logic               wr_act;
   logic               commit;
   logic               rom_start;

   sms_mapper_decode #(
      .ROM_AW  (ROM_AW),
      .RAM_AW  (RAM_AW),
      .CRAM_AW (CRAM_AW)
   ) u_decode (
      .addr_i      (z_addr),
      .regs_i      (regs_q),
      .region_o    (region),
      .rom_addr_o  (dec_rom_addr),
      .ram_addr_o  (ram_addr),
      .cram_addr_o (cram_addr)
   );

   always_comb begin
      rd_act    = !z_nmreq && !z_nrd && z_nrfsh;
      wr_act    = !z_nmreq && !z_nwr && z_nrfsh;
      commit    = wr_act && !wr_prev_q;
      rom_start = (state_q == IDLE) && rd_act && (region == REG_ROM);
   end

   // Request/wait are combinational so the CPU is stalled in the same clock; reset forces them idle.
   assign rom_rd   = !reset && ((state_q == ROM_REQ) || rom_start);
   assign z_nwait  = !rom_rd;
   assign rom_addr = (state_q == ROM_REQ) ? rom_addr_q : dec_rom_addr;
   assign ram_we   = !reset && commit && (region == REG_RAM);
   assign cram_we  = !reset && commit && (region == REG_CRAM);
   assign z_din    = z_din_q;

   // Write edge detect and mapper registers (FFFC-FFFF also land in system RAM).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_prev_q <= 1'b0;
         regs_q    <= '{cram_en: 1'b0, cram_bank: 1'b0,
                        b0: BANK0_RST, b1: BANK1_RST, b2: BANK2_RST};
      end else begin
         wr_prev_q <= wr_act;
         if (commit) begin
            unique case (z_addr)
               MAP_CTL: begin
                  regs_q.cram_en   <= z_dout[3];
                  regs_q.cram_bank <= z_dout[2];
               end
               MAP_B0:  regs_q.b0 <= z_dout;
               MAP_B1:  regs_q.b1 <= z_dout;
               MAP_B2:  regs_q.b2 <= z_dout;
               default: ;
            endcase
         end
      end
   end

   // Read FSM: RAM reads finish in one clock, ROM reads wait for rom_ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         z_din_q    <= 8'hFF;
         rom_addr_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               abort_q <= 1'b0;
               if (rd_act) begin
                  if (region == REG_ROM) begin
                     state_q    <= ROM_REQ;
                     rom_addr_q <= dec_rom_addr;
                  end else begin
                     state_q <= DONE;
                     z_din_q <= (region == REG_CRAM) ? cram_q : ram_q;
                  end
               end
            end
            ROM_REQ: begin
               if (!rd_act) abort_q <= 1'b1;
               if (rom_ready) begin
                  abort_q <= 1'b0;
                  if (rd_act && !abort_q) begin
                     state_q <= DONE;
                     z_din_q <= rom_data;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            DONE: begin
               if (!rd_act) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sms_mapper.md
Name: sms_mapper

Overview:
- Sits directly downstream of the A-Z80 top pins and translates raw Z80 bus cycles into SMS memory traffic.
- Decodes the 64 KB CPU space into banked cartridge ROM, optional cartridge RAM and 8 KB mirrored system RAM.
- Holds the Sega mapper registers at FFFC-FFFF.
- Stretches ROM reads via nWAIT until the external ROM port acknowledges.

Parameters:
- ROM_AW, 22, ROM byte-address width (4 MB max); bank number masked to ROM_AW-14 bits.
- RAM_AW, 13, system RAM address width (8 KB, mirrored across C000-FFFF).
- CRAM_AW, 15, cartridge RAM address width (2 x 16 KB banks).

Ports:
- clk  in  1  system clock, same clk that drives the CPU core
- reset  in  1  asynchronous, active-high reset
- z_addr  in  16  CPU address pins A
- z_dout  in  8  CPU data being written (D when nWR low)
- z_din  out  8  data returned to CPU D pins
- z_nmreq  in  1  CPU nMREQ
- z_nrd  in  1  CPU nRD
- z_nwr  in  1  CPU nWR
- z_nrfsh  in  1  CPU nRFSH
- z_nwait  out  1  to CPU nWAIT
- rom_addr  out  ROM_AW  ROM byte address
- rom_rd  out  1  ROM read request, held until rom_ready
- rom_ready  in  1  ROM data valid, single-cycle pulse
- rom_data  in  8  ROM read data
- ram_addr  out  RAM_AW  system RAM address
- ram_we  out  1  system RAM write, one-cycle pulse
- ram_q  in  8  system RAM read data (combinational/same-cycle)
- cram_addr  out  CRAM_AW  cartridge RAM address
- cram_we  out  1  cartridge RAM write, one-cycle pulse
- cram_q  in  8  cartridge RAM read data

Behaviour:
- Reset values: reg_ctl (FFFC) = 00, bank0/1/2 (FFFD/FFFE/FFFF) = 00/01/02, z_nwait = 1, rom_rd = 0, ram_we = 0, cram_we = 0, z_din = FF, FSM = IDLE.
- Decode is combinational on z_addr:
  - 0000-03FF: ROM page 0, unbanked.
  - 0400-3FFF: bank0.
  - 4000-7FFF: bank1.
  - 8000-BFFF: cartridge RAM if reg_ctl[3], at {reg_ctl[2], a[13:0]}; otherwise ROM bank2.
  - C000-FFFF: system RAM at a[RAM_AW-1:0].
- rom_addr = {bank & mask, a[13:0]}.
- Refresh cycles (z_nrfsh=0) are ignored entirely: no request, no write, no wait.
- Write detect: wr_act = !z_nmreq & !z_nwr & z_nrfsh. A write commits on the first clk where wr_act=1 and the registered previous wr_act=0, so exactly one commit per CPU write.
- On commit:
  - RAM/cartridge-RAM region: one-cycle ram_we or cram_we pulse.
  - ROM region: no effect.
  - Addresses FFFC-FFFF: update the matching mapper register in the same cycle as the RAM write (RAM is also written).
- Read FSM states:
  - IDLE: on rd_act = !z_nmreq & !z_nrd & z_nrfsh:
    - ROM target -> ROM_REQ, rom_rd=1, z_nwait=0 (same cycle, combinational from state/decode).
    - RAM/cartridge-RAM target -> DONE, z_din = ram_q/cram_q, registered.
  - ROM_REQ: hold rom_rd=1, rom_addr stable, z_nwait=0. On rom_ready: latch rom_data into z_din, rom_rd=0 -> DONE.
  - DONE: z_nwait=1, z_din held. When rd_act drops -> IDLE.
- Read latency: RAM 1 clk; ROM 1 clk after rom_ready.
- Boundary conditions:
  - rd_act dropping in ROM_REQ (aborted cycle): keep rom_rd until rom_ready, discard the data, return to IDLE.
  - Mapper write during a ROM fetch: impossible on a Z80; bank registers are not re-sampled while in ROM_REQ.
  - Bank value above the ROM size wraps via the mask.
  - Asynchronous reset mid-cycle: immediately drop rom_rd, release z_nwait, restore register defaults.

Decomposition:
- sms_pkg holds:
  - region enum: REG_ROM, REG_CRAM, REG_RAM
  - FSM state enum: IDLE, ROM_REQ, DONE
  - mapper addresses: MAP_CTL=FFFC, MAP_B0=FFFD, MAP_B1=FFFE, MAP_B2=FFFF
  - reset bank defaults
- One natural sub-module, sms_mapper_decode: purely combinational address->region/target address using the current registers. Registers, write detect and FSM remain in sms_mapper.

Test Plan:
- Reset, then read 0x4123 -> rom_rd with rom_addr=0x04123. z_nwait low until rom_ready with rom_data=5A; z_din=5A one clk later; z_nwait high.
- Write 07 to FFFF, then read 0x8001 -> ram_we pulse at ram_addr=0x1FFF; rom_addr=0x1C001 on the read.
- Write 08 to FFFC, write 3C to 0x8010, read 0x8010 -> cram_we once at cram_addr=0x0010; read returns 3C with no rom_rd and z_nwait never low.
- Write 05 to FFFD, read 0x0200 and 0x0400 -> rom_addr 0x00200 (unbanked) and 0x14400.
- Refresh cycle (z_nrfsh=0, z_nmreq=0) at 0x4000 -> no rom_rd, no writes, z_nwait stays 1.
- Assert reset during ROM_REQ -> rom_rd=0 and z_nwait=1 in the same cycle; bank regs back to 00/01/02; next read of 0x8000 -> rom_addr=0x08000.
